// File: rtl/regfile_mp.sv
// Multi-port integer register file: two write lanes (wr1 wins), busy scoreboard, post-reset zeroing FSM.
// Define RF_BYPASS_EN to forward same-cycle qualified writes to read ports and busy outputs.
module regfile_mp #(
    parameter int NUM_REGS = 32,
    parameter int XLEN     = 32,
    parameter int NRD      = 2,
    parameter int RSLEN    = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  init_done,
    input  logic [NRD*RSLEN-1:0]  rd_addr,
    output logic [NRD*XLEN-1:0]   rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  wr0_en,
    input  logic [RSLEN-1:0]      wr0_addr,
    input  logic [XLEN-1:0]       wr0_data,
    input  logic                  wr1_en,
    input  logic [RSLEN-1:0]      wr1_addr,
    input  logic [XLEN-1:0]       wr1_data,
    input  logic                  iss_en,
    input  logic [RSLEN-1:0]      iss_addr
);

    typedef enum logic {INIT, RUN} state_t;

    state_t                         state;
    logic [RSLEN-1:0]               cnt;
    logic [NUM_REGS-1:0][XLEN-1:0]  rf;
    logic [NUM_REGS-1:0]            busy, busy_nxt;
    logic                           we0, we1, iss_q;

    assign we0   = wr0_en & (wr0_addr != '0) & init_done;
    assign we1   = wr1_en & (wr1_addr != '0) & init_done;
    assign iss_q = iss_en & (iss_addr != '0) & init_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= INIT;
            cnt       <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    cnt <= cnt + RSLEN'(1);
                    if (cnt == RSLEN'(NUM_REGS - 1)) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end
                end
                RUN:     state <= RUN;
                default: state <= INIT;
            endcase
        end
    end

    // Storage has no reset; the INIT sweep zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            rf[cnt] <= '0;
        end else begin
            if (we0 && !(we1 && (wr1_addr == wr0_addr)))
                rf[wr0_addr] <= wr0_data;
            if (we1)
                rf[wr1_addr] <= wr1_data;
        end
    end

    // Issue set is applied last so a newer producer beats a retiring one.
    always_comb begin
        busy_nxt = busy;
        if (we0)   busy_nxt[wr0_addr] = 1'b0;
        if (we1)   busy_nxt[wr1_addr] = 1'b0;
        if (iss_q) busy_nxt[iss_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) busy <= '0;
        else      busy <= busy_nxt;
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [RSLEN-1:0] a;
        logic [XLEN-1:0]  d;
        logic             b;

        assign a = rd_addr[i*RSLEN +: RSLEN];

        always_comb begin
            d = rf[a];
            b = busy[a];
`ifdef RF_BYPASS_EN
            if (we0 && (a == wr0_addr)) d = wr0_data;
            if (we1 && (a == wr1_addr)) d = wr1_data;
            if (((we0 && (a == wr0_addr)) || (we1 && (a == wr1_addr))) &&
                !(iss_q && (a == iss_addr)))
                b = 1'b0;
`endif
            if (!init_done || (a == '0)) d = '0;
            if (!init_done)              b = 1'b0;
        end

        assign rd_data[i*XLEN +: XLEN] = d;
        assign rd_busy[i]              = b;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with a per-cycle reference model of the register file and scoreboard.
module tb_regfile_mp;

    localparam int NR = 32;
    localparam int XL = 32;
    localparam int NP = 2;
    localparam int AL = 5;

`ifdef RF_BYPASS_EN
    localparam logic [31:0] R5_SAME = 32'hDEAD_BEEF;
`else
    localparam logic [31:0] R5_SAME = 32'h0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             init_done;
    logic [NP*AL-1:0] rd_addr;
    logic [NP*XL-1:0] rd_data;
    logic [NP-1:0]    rd_busy;
    logic             wr0_en = 1'b0, wr1_en = 1'b0, iss_en = 1'b0;
    logic [AL-1:0]    wr0_addr = '0, wr1_addr = '0, iss_addr = '0;
    logic [XL-1:0]    wr0_data = '0, wr1_data = '0;
    logic [AL-1:0]    ra [NP];

    assign rd_addr = {ra[1], ra[0]};

    regfile_mp #(.NUM_REGS(NR), .XLEN(XL), .NRD(NP)) dut (
        .clk(clk), .rst(rst), .init_done(init_done),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .iss_en(iss_en), .iss_addr(iss_addr)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an array of values and busy flags, plus a count of init cycles.
    logic [31:0] m_rf   [NR];
    logic        m_busy [NR];
    logic        m_done;
    int          m_cyc;

    function automatic logic q0();
        return wr0_en && (wr0_addr != 0) && m_done;
    endfunction
    function automatic logic q1();
        return wr1_en && (wr1_addr != 0) && m_done;
    endfunction
    function automatic logic qi();
        return iss_en && (iss_addr != 0) && m_done;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_done <= 1'b0;
            m_cyc  <= 0;
            for (int r = 0; r < NR; r++) begin
                m_rf[r]   <= '0;
                m_busy[r] <= 1'b0;
            end
        end else if (!m_done) begin
            m_cyc <= m_cyc + 1;
            if (m_cyc + 1 == NR) m_done <= 1'b1;
        end else begin
            if (q0()) begin
                m_rf[wr0_addr]   <= wr0_data;
                m_busy[wr0_addr] <= 1'b0;
            end
            if (q1()) begin
                m_rf[wr1_addr]   <= wr1_data;
                m_busy[wr1_addr] <= 1'b0;
            end
            if (qi()) m_busy[iss_addr] <= 1'b1;
        end
    end

    function automatic logic [31:0] exp_data(input logic [AL-1:0] a);
        if (!m_done || a == 0) return 32'h0;
`ifdef RF_BYPASS_EN
        if (q1() && a == wr1_addr) return wr1_data;
        if (q0() && a == wr0_addr) return wr0_data;
`endif
        return m_rf[a];
    endfunction

    function automatic logic exp_busy(input logic [AL-1:0] a);
        if (!m_done) return 1'b0;
`ifdef RF_BYPASS_EN
        if (((q0() && a == wr0_addr) || (q1() && a == wr1_addr)) && !(qi() && a == iss_addr))
            return 1'b0;
`endif
        return m_busy[a];
    endfunction

    always @(negedge clk) begin
        chk("cmp_init_done", 32'(init_done), 32'(m_done));
        for (int p = 0; p < NP; p++) begin
            chk($sformatf("cmp_rd_data%0d", p), rd_data[p*XL +: XL], exp_data(ra[p]));
            chk($sformatf("cmp_rd_busy%0d", p), 32'(rd_busy[p]), 32'(exp_busy(ra[p])));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr0_en = 1'b0;
        wr1_en = 1'b0;
        iss_en = 1'b0;
    endtask

    task automatic wait_init(input string nm);
        int n;
        n = 0;
        for (int k = 1; k <= 100; k++) begin
            cyc();
            if (k == 10) begin
                wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'hA5A5;
            end else begin
                wr0_en = 1'b0;
            end
            if (init_done) begin
                n = k;
                break;
            end
        end
        wr0_en = 1'b0;
        chk(nm, 32'(n), 32'd32);
    endtask

    initial begin
        ra[0] = '0;
        ra[1] = '0;
        #1 rst = 1'b0;
        #1 chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_busy", 32'(rd_busy), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        wait_init("init_latency");

        ra[0] = 5'd3; ra[1] = 5'd3;
        #1 chk("r3_init_write_ignored", rd_data[31:0], 32'h0);

        wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'h1234_5678;
        wr1_en = 1'b1; wr1_addr = 5'd5; wr1_data = 32'hDEAD_BEEF;
        ra[0] = 5'd5; ra[1] = 5'd5;
        #1 chk("r5_same_cycle", rd_data[31:0], R5_SAME);
        cyc(); idle();
        #1 chk("r5_wr1_wins_p0", rd_data[31:0], 32'hDEAD_BEEF);
        chk("r5_wr1_wins_p1", rd_data[63:32], 32'hDEAD_BEEF);

        wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hFFFF_FFFF;
        wr1_en = 1'b1; wr1_addr = 5'd0; wr1_data = 32'hFFFF_FFFF;
        iss_en = 1'b1; iss_addr = 5'd0;
        ra[0] = 5'd0; ra[1] = 5'd0;
        #1 chk("r0_same_cycle", rd_data[31:0], 32'h0);
        cyc(); idle();
        #1 chk("r0_p0", rd_data[31:0], 32'h0);
        chk("r0_p1", rd_data[63:32], 32'h0);
        chk("r0_busy", 32'(rd_busy), 32'd0);

        iss_en = 1'b1; iss_addr = 5'd7;
        ra[0] = 5'd7; ra[1] = 5'd7;
        cyc(); idle();
        #1 chk("r7_busy_set", 32'(rd_busy[0]), 32'd1);
        wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h55;
        iss_en = 1'b1; iss_addr = 5'd7;
        cyc(); idle();
        #1 chk("r7_set_beats_clear", 32'(rd_busy[1]), 32'd1);
        chk("r7_data_55", rd_data[31:0], 32'h55);
        wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h66;
        cyc(); idle();
        #1 chk("r7_busy_clear", 32'(rd_busy[0]), 32'd0);
        chk("r7_data_66", rd_data[31:0], 32'h66);

        wr0_en = 1'b1; wr0_addr = 5'd10; wr0_data = 32'h1010;
        wr1_en = 1'b1; wr1_addr = 5'd11; wr1_data = 32'h1111;
        ra[0] = 5'd10; ra[1] = 5'd11;
        cyc(); idle();
        #1 chk("r10_lane0", rd_data[31:0], 32'h1010);
        chk("r11_lane1", rd_data[63:32], 32'h1111);

        wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h99;
        iss_en = 1'b1; iss_addr = 5'd12;
        ra[0] = 5'd9; ra[1] = 5'd12;
        cyc(); idle();
        #1 chk("r9_written", rd_data[31:0], 32'h99);
        chk("r12_busy", 32'(rd_busy[1]), 32'd1);
        rst = 1'b0;
        #1 chk("midrun_init_done_drop", 32'(init_done), 32'd0);
        chk("midrun_outputs_zero", rd_data[31:0], 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        wait_init("reinit_latency");
        ra[0] = 5'd9; ra[1] = 5'd12;
        #1 chk("r9_cleared", rd_data[31:0], 32'h0);
        chk("r12_busy_cleared", 32'(rd_busy[1]), 32'd0);
        for (int a = 0; a < NR; a++) begin
            ra[0] = AL'(a);
            ra[1] = AL'(NR - 1 - a);
            #1 chk($sformatf("post_reset_busy_%0d", a), 32'(rd_busy), 32'd0);
        end

        repeat (2) cyc();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
        $fatal(1, "watchdog");
    end

endmodule
